// File: rtl/tpu_isa_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tpu_isa_pkg: instruction field layout, opcodes and issuer states.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package tpu_isa_pkg;

    localparam int INSTR_W = 32;
    localparam int OPC_LSB = 26;
    localparam int OPC_W   = 6;

    localparam logic [OPC_W-1:0] OP_NOP    = 6'h00;
    localparam logic [OPC_W-1:0] OP_MATMUL = 6'h10;
    localparam logic [OPC_W-1:0] OP_SYNC   = 6'h30;
    localparam logic [OPC_W-1:0] OP_HALT   = 6'h3F;

    localparam logic [INSTR_W-1:0] NOP_WORD = {OP_NOP, {(INSTR_W-OPC_W){1'b0}}};

    // Execution-unit class carried in opcode[5:4]
    typedef enum logic [1:0] {
        CLS_DMA  = 2'b00,
        CLS_MM   = 2'b01,
        CLS_VPU  = 2'b10,
        CLS_SYNC = 2'b11
    } op_class_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_GUARD  = 2'd2,
        ST_HALTED = 2'd3
    } issuer_state_e;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] w);
        return w[OPC_LSB +: OPC_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/tpu_instr_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tpu_instr_fifo: DEPTHx32 synchronous FIFO with combinational head. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tpu_instr_fifo
    import tpu_isa_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [INSTR_W-1:0]         wr_data,
    input  logic                       rd_en,
    output logic [INSTR_W-1:0]         rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        cnt_q, cnt_d;
    logic               push;
    logic               pop;

    // A full queue rejects the write even when a pop frees a slot this cycle
    assign push = wr_en && (cnt_q != AW'(0) + (AW+1)'(DEPTH)) ? 1'b1 : 1'b0;
    assign pop  = rd_en && (cnt_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;

endmodule
`default_nettype wire

// File: rtl/tpu_instr_issuer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tpu_instr_issuer: queues host instructions and issues each as a    |
// | one-cycle pulse once its execution units are idle.  Revision: 1.0  |
// +--------------------------------------------------------------------+
module tpu_instr_issuer
    import tpu_isa_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       host_wr_en,
    input  logic [31:0]                host_wr_data,
    output logic                       host_full,
    output logic [$clog2(DEPTH):0]     q_count,
    input  logic                       sys_busy,
    input  logic                       wt_busy,
    input  logic                       vpu_busy,
    input  logic                       dma_busy,
    output logic [31:0]                instr_data,
    output logic                       running,
    output logic                       halted,
    output logic [CNT_W-1:0]           issue_count
);

    issuer_state_e      state_q, state_d;
    logic [31:0]        instr_q, instr_d;
    logic               halted_q, halted_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [31:0]        head;
    logic               q_empty;
    logic               pop;
    logic               res_free;
    logic [OPC_W-1:0]   head_op;

    tpu_instr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (host_wr_en),
        .wr_data (host_wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (host_full),
        .empty   (q_empty),
        .count   (q_count)
    );

    assign head_op = opcode_of(head);

    always_comb begin
        res_free = 1'b0;
        unique case (op_class_e'(head_op[5:4]))
            CLS_DMA:  res_free = !dma_busy;
            CLS_MM:   res_free = !sys_busy && !wt_busy;
            CLS_VPU:  res_free = !vpu_busy;
            CLS_SYNC: res_free = !sys_busy && !wt_busy && !vpu_busy && !dma_busy;
        endcase
    end

    // instr_d defaults to NOP every cycle, which makes each issue a single-cycle pulse
    always_comb begin
        state_d  = state_q;
        instr_d  = NOP_WORD;
        halted_d = halted_q;
        cnt_d    = cnt_q;
        pop      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!q_empty) begin
                    if (head_op == OP_HALT) begin
                        pop      = 1'b1;
                        halted_d = 1'b1;
                        state_d  = ST_HALTED;
                    end else if (res_free) begin
                        pop     = 1'b1;
                        instr_d = head;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = ST_GUARD;
                    end
                end
            end
            ST_GUARD: begin
                state_d = ST_RUN;
            end
            ST_HALTED: begin
                if (start) begin
                    halted_d = 1'b0;
                    state_d  = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            instr_q  <= '0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    assign instr_data  = instr_q;
    assign running     = (state_q == ST_RUN) || (state_q == ST_GUARD);
    assign halted      = halted_q;
    assign issue_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tpu_instr_issuer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_tpu_instr_issuer: directed scoreboard bench for the issuer.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_tpu_instr_issuer;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   start;
    logic                   host_wr_en;
    logic [31:0]            host_wr_data;
    logic                   host_full;
    logic [$clog2(DEPTH):0] q_count;
    logic                   sys_busy, wt_busy, vpu_busy, dma_busy;
    logic [31:0]            instr_data;
    logic                   running;
    logic                   halted;
    logic [CNT_W-1:0]       issue_count;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] sb[$];
    logic        prev_nz = 1'b0;

    always #5 clk = ~clk;

    tpu_instr_issuer #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .host_wr_en   (host_wr_en),
        .host_wr_data (host_wr_data),
        .host_full    (host_full),
        .q_count      (q_count),
        .sys_busy     (sys_busy),
        .wt_busy      (wt_busy),
        .vpu_busy     (vpu_busy),
        .dma_busy     (dma_busy),
        .instr_data   (instr_data),
        .running      (running),
        .halted       (halted),
        .issue_count  (issue_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w, input bit expect_issue);
        host_wr_en   = 1'b1;
        host_wr_data = w;
        step();
        host_wr_en   = 1'b0;
        if (expect_issue) sb.push_back(w);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_count(input logic [CNT_W-1:0] target, input int budget);
        int n = 0;
        while (issue_count !== target && n < budget) begin
            step();
            n++;
        end
        check("wait_issue_count", 32'(issue_count), 32'(target));
    endtask

    // Scoreboard monitor: every non-NOP word must match the next expected issue
    always @(negedge clk) begin
        if (rst_n === 1'b1 && instr_data !== 32'h0) begin
            if (sb.size() == 0) begin
                check("unexpected_issue", instr_data, 32'h0);
            end else begin
                check("sb_issue", instr_data, sb.pop_front());
            end
            check("pulse_gap", 32'(prev_nz), 32'h0);
            prev_nz <= 1'b1;
        end else begin
            prev_nz <= 1'b0;
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; host_wr_en = 1'b0; host_wr_data = '0;
        sys_busy = 1'b0; wt_busy = 1'b0; vpu_busy = 1'b0; dma_busy = 1'b0;
        repeat (3) step();
        check("rst_instr", instr_data, 32'h0);
        check("rst_flags", {28'h0, host_full, running, halted, 1'b0}, 32'h0);
        check("rst_qcount", 32'(q_count), 32'h0);
        check("rst_count", 32'(issue_count), 32'h0);
        rst_n = 1'b1;
        step();

        // MATMUL then HALT
        push(32'h40008010, 1'b1);
        push(32'hFC000000, 1'b0);
        check("t1_qcount", 32'(q_count), 32'd2);
        pulse_start();
        check("t1_not_early", instr_data, 32'h0);
        check("t1_running", 32'(running), 32'd1);
        step();
        check("t1_issue", instr_data, 32'h40008010);
        step();
        check("t1_pulse_end", instr_data, 32'h0);
        repeat (2) step();
        check("t1_halted", 32'(halted), 32'd1);
        check("t1_not_running", 32'(running), 32'd0);
        check("t1_count", 32'(issue_count), 32'd1);
        check("t1_qempty", 32'(q_count), 32'd0);

        // Queue retained across HALT, resumed by start
        push(32'h04000001, 1'b1);
        push(32'h80000008, 1'b1);
        repeat (2) step();
        check("t6_held", 32'(issue_count), 32'd1);
        check("t6_qcount", 32'(q_count), 32'd2);
        pulse_start();
        check("t6_halted_clr", 32'(halted), 32'd0);
        wait_count(16'd3, 20);
        repeat (2) step();
        check("t6_qempty", 32'(q_count), 32'd0);

        // SYNC withheld while the vector unit is busy
        vpu_busy = 1'b1;
        push(32'h40008010, 1'b1);
        push(32'hC0000004, 1'b1);
        wait_count(16'd4, 10);
        repeat (4) step();
        check("t2_withheld", instr_data, 32'h0);
        check("t2_count", 32'(issue_count), 32'd4);
        check("t2_qcount", 32'(q_count), 32'd1);
        vpu_busy = 1'b0;
        step();
        check("t2_sync", instr_data, 32'hC0000004);
        step();
        check("t2_pulse_end", instr_data, 32'h0);

        // MATMUL gated by both systolic and weight-loader busy
        sys_busy = 1'b1;
        push(32'h41234560, 1'b1);
        repeat (3) step();
        check("t4_sys_hold", instr_data, 32'h0);
        sys_busy = 1'b0; wt_busy = 1'b1;
        repeat (2) step();
        check("t4_wt_hold", instr_data, 32'h0);
        wt_busy = 1'b0;
        #1;
        check("t4_no_comb", instr_data, 32'h0);
        step();
        check("t4_issue", instr_data, 32'h41234560);
        check("t4_count", 32'(issue_count), 32'd6);
        repeat (2) step();

        // Reset while in GUARD with five entries queued
        dma_busy = 1'b1;
        for (int i = 0; i < 6; i++) push(32'h04000010 + 32'(i), 1'b1);
        check("t5_qcount6", 32'(q_count), 32'd6);
        dma_busy = 1'b0;
        step();
        check("t5_issue", instr_data, 32'h04000010);
        check("t5_qcount5", 32'(q_count), 32'd5);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_async_instr", instr_data, 32'h0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        check("t5_qcount", 32'(q_count), 32'd0);
        check("t5_count", 32'(issue_count), 32'd0);
        check("t5_idle", {30'h0, running, halted}, 32'h0);

        // Fill past DEPTH in IDLE, then drain at 2-cycle spacing
        for (int i = 0; i < 17; i++) begin
            host_wr_en   = 1'b1;
            host_wr_data = 32'h04000100 + 32'(i);
            step();
            if (i < DEPTH) sb.push_back(32'h04000100 + 32'(i));
        end
        host_wr_en = 1'b0;
        step();
        check("t3_full", 32'(host_full), 32'd1);
        check("t3_qcount", 32'(q_count), 32'd16);
        check("t3_idle_no_issue", 32'(issue_count), 32'd0);
        pulse_start();
        // A write while full is dropped even though the first pop happens this cycle
        host_wr_en   = 1'b1;
        host_wr_data = 32'h0BAD0000;
        step();
        host_wr_en = 1'b0;
        check("t3_drop_on_pop", 32'(q_count), 32'd15);
        check("t3_first", instr_data, 32'h04000100);
        step();
        check("t3_gap0", instr_data, 32'h0);
        for (int i = 1; i < DEPTH; i++) begin
            step();
            check("t3_issue", instr_data, 32'h04000100 + 32'(i));
            step();
            check("t3_gap", instr_data, 32'h0);
        end
        repeat (3) step();
        check("t3_count", 32'(issue_count), 32'd16);
        check("t3_qempty", 32'(q_count), 32'd0);
        check("t3_not_full", 32'(host_full), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
